// File: rtl/instr_fetch_pkg.sv
// Shared instruction-word field layout, halt opcode and fetch FSM encoding.
// Imported by the fetch sequencer, the control unit and their benches.
package instr_fetch_pkg;

  localparam logic [2:0] HALT_OPCODE = 3'b111;

  typedef struct packed {
    logic [2:0] opcode;  // [15:13]
    logic [2:0] rsel;    // [12:10]
    logic [9:0] imm;     // [9:0]
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    instr_t fields;
    fields = instr_t'(word);
    return fields.opcode;
  endfunction

  function automatic logic [2:0] reg_of(input logic [15:0] word);
    instr_t fields;
    fields = instr_t'(word);
    return fields.rsel;
  endfunction

  function automatic logic [9:0] imm_of(input logic [15:0] word);
    instr_t fields;
    fields = instr_t'(word);
    return fields.imm;
  endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: DEPTH x 16, synchronous write, registered read.
// The read register is the instruction register seen by the control unit.
module prog_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              Resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem_reg [DEPTH];
  logic [15:0] rdata_reg;

  // Array kept free of reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: loads a program, then issues words in PC order
// and holds each until the control unit reports done, stopping on HALT_OP.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         ADDR_W  = 4,
  parameter logic [2:0] HALT_OP = HALT_OPCODE
) (
  input  logic              clock,
  input  logic              Resetn,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              run,
  input  logic              done,
  output logic [15:0]       iin,
  output logic              iin_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              iin_valid_reg;
  logic              halted_reg;
  logic [15:0]       mem_rdata;
  logic              mem_we;
  logic              mem_re;

  // Loads are only accepted while not sequencing, so a write never races a fetch.
  assign mem_we = Resetn && load_en && ((state_reg == ST_IDLE) || (state_reg == ST_HALT));
  assign mem_re = (state_reg == ST_FETCH);

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clock  (clock),
    .Resetn (Resetn),
    .we     (mem_we),
    .waddr  (load_addr),
    .wdata  (load_data),
    .re     (mem_re),
    .raddr  (pc_reg),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      iin_valid_reg <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
          end
        end
        ST_FETCH: begin
          state_reg     <= ST_ISSUE;
          iin_valid_reg <= 1'b1;
        end
        ST_ISSUE: begin
          // A halt word stops without waiting for done and leaves pc on it.
          if (opcode_of(mem_rdata) == HALT_OP) begin
            state_reg     <= ST_HALT;
            iin_valid_reg <= 1'b0;
            halted_reg    <= 1'b1;
          end else if (done) begin
            state_reg     <= ST_FETCH;
            iin_valid_reg <= 1'b0;
            pc_reg        <= pc_reg + ADDR_W'(1);
          end
        end
        ST_HALT: begin
          if (run) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= '0;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign iin       = mem_rdata;
  assign iin_valid = iin_valid_reg;
  assign pc        = pc_reg;
  assign halted    = halted_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the sequencer.
module tb_instr_fetch;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = 4'd0;
  logic [15:0] load_data = 16'h0000;
  logic        run = 1'b0;
  logic        done = 1'b0;
  logic [15:0] iin;
  logic        iin_valid;
  logic [3:0]  pc;
  logic        halted;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  instr_fetch #(
    .DEPTH   (16),
    .ADDR_W  (4),
    .HALT_OP (3'b111)
  ) dut (
    .clock     (clock),
    .Resetn    (Resetn),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .run       (run),
    .done      (done),
    .iin       (iin),
    .iin_valid (iin_valid),
    .pc        (pc),
    .halted    (halted)
  );

  // Reference model: program image plus "what is on the bus" and a pending-fetch flag.
  bit [15:0] m_mem [DEPTH];
  bit [15:0] m_iin = 16'h0000;
  bit        m_valid = 1'b0;
  bit        m_halted = 1'b0;
  bit        m_fetch = 1'b0;
  int        m_pc = 0;

  always @(posedge clock) begin
    if (!Resetn) begin
      m_iin = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_fetch = 1'b0; m_pc = 0;
    end else if (m_fetch) begin
      m_iin = m_mem[m_pc]; m_valid = 1'b1; m_fetch = 1'b0;
    end else if (m_valid) begin
      if (m_iin[15:13] == 3'b111) begin
        m_valid = 1'b0; m_halted = 1'b1;
      end else if (done) begin
        m_valid = 1'b0; m_pc = (m_pc + 1) % DEPTH; m_fetch = 1'b1;
      end
    end else begin
      if (load_en) m_mem[load_addr] = load_data;
      if (run) begin
        m_pc = 0; m_halted = 1'b0; m_fetch = 1'b1;
      end
    end
  end

  // Literal expectations requested by the directed sequence.
  bit          chk_en = 1'b0;
  int          lit_seq = 0;
  int          lit_seen = 0;
  int          lit_kind = 0;
  string       lit_name = "";
  logic [15:0] lit_iin = 16'h0000;
  logic        lit_v = 1'b0;
  logic [3:0]  lit_pc = 4'd0;
  logic        lit_h = 1'b0;
  int          wraps = 0;
  int          last_pc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model.iin", 32'(iin), 32'(m_iin));
      check("model.iin_valid", 32'(iin_valid), 32'(m_valid));
      check("model.pc", 32'(pc), 32'(m_pc[3:0]));
      check("model.halted", 32'(halted), 32'(m_halted));
      if (iin_valid === 1'b1) begin
        if (last_pc == 15 && pc == 4'd0) wraps++;
        last_pc = int'(pc);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        if (lit_kind == 0) begin
          check({lit_name, ".iin"}, 32'(iin), 32'(lit_iin));
          check({lit_name, ".iin_valid"}, 32'(iin_valid), 32'(lit_v));
          check({lit_name, ".pc"}, 32'(pc), 32'(lit_pc));
          check({lit_name, ".halted"}, 32'(halted), 32'(lit_h));
        end else begin
          check(lit_name, 32'(wraps > 0), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] e_iin, input logic e_v,
                            input logic [3:0] e_pc, input logic e_h);
    lit_kind = 0; lit_name = name;
    lit_iin = e_iin; lit_v = e_v; lit_pc = e_pc; lit_h = e_h;
    lit_seq++;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1; tick(); run = 1'b0; tick();
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0; tick();
  endtask

  initial begin
    // Reset and idle
    tick(); tick();
    chk_en = 1'b1;
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out("idle", 16'h0000, 1'b0, 4'd0, 1'b0);
      tick();
    end

    // Load and issue
    load_word(4'd0, 16'hA01C);
    load_word(4'd1, 16'hA40A);
    load_word(4'd2, 16'h2080);
    load_word(4'd3, 16'hE000);
    pulse_run();
    expect_out("first", 16'hA01C, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    done = 1'b1; tick(); done = 1'b0;
    expect_out("gap", 16'hA01C, 1'b0, 4'd1, 1'b0);
    tick();
    expect_out("second", 16'hA40A, 1'b1, 4'd1, 1'b0);

    // Stall with an ignored load attempt
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        load_en = 1'b1; load_addr = 4'd1; load_data = 16'hFFFF;
      end else begin
        load_en = 1'b0;
      end
      tick();
    end
    load_en = 1'b0;
    expect_out("stall", 16'hA40A, 1'b1, 4'd1, 1'b0);

    // Run to halt; done in HALT is ignored
    pulse_done();
    expect_out("third", 16'h2080, 1'b1, 4'd2, 1'b0);
    pulse_done();
    expect_out("haltword", 16'hE000, 1'b1, 4'd3, 1'b0);
    tick();
    expect_out("halt", 16'hE000, 1'b0, 4'd3, 1'b1);
    pulse_done();
    expect_out("halt_done", 16'hE000, 1'b0, 4'd3, 1'b1);

    // Restart and confirm mem[1] survived the blocked load
    pulse_run();
    expect_out("restart", 16'hA01C, 1'b1, 4'd0, 1'b0);
    pulse_done();
    expect_out("mem1_kept", 16'hA40A, 1'b1, 4'd1, 1'b0);
    pulse_done();
    expect_out("pc2", 16'h2080, 1'b1, 4'd2, 1'b0);

    // Reset mid-run together with done
    Resetn = 1'b0; done = 1'b1;
    tick();
    expect_out("midreset", 16'h0000, 1'b0, 4'd0, 1'b0);
    Resetn = 1'b1; done = 1'b0;
    tick();
    pulse_run();
    expect_out("rerun", 16'hA01C, 1'b1, 4'd0, 1'b0);

    // Wrap: no halt anywhere, done held high
    Resetn = 1'b0; tick(); Resetn = 1'b1;
    for (int a = 0; a < DEPTH; a++) load_word(4'(a), 16'h2080);
    done = 1'b1;
    run = 1'b1; tick(); run = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    lit_kind = 1; lit_name = "wrap"; lit_seq++;
    tick();
    done = 1'b0;

    // Randomized traffic
    Resetn = 1'b0; tick(); Resetn = 1'b1;
    for (int a = 0; a < DEPTH; a++) load_word(4'(a), 16'($urandom));
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 7) == 0);
      done      = ($urandom_range(0, 1) == 1);
      load_en   = ($urandom_range(0, 9) == 0);
      load_addr = 4'($urandom_range(0, 15));
      load_data = 16'($urandom);
      Resetn    = ($urandom_range(0, 299) != 0);
      tick();
    end
    run = 1'b0; done = 1'b0; load_en = 1'b0; Resetn = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
